// File: rtl/alu_pkg.sv
// Shared decode constants for the execute-stage ALU/MDU: control codes, funct3/funct7 fields, alu_op encodings.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;
  localparam logic [3:0] ALU_MDU    = 4'b1011;

  localparam logic [1:0] AOP_ADD    = 2'b00;
  localparam logic [1:0] AOP_SUB    = 2'b01;
  localparam logic [1:0] AOP_FUNCT  = 2'b10;
  localparam logic [1:0] AOP_PASS_B = 2'b11;

  // Base integer funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/div_serial.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, sign fix-up applied on the outputs.
module div_serial #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient_c,
  output logic [XLEN-1:0] remainder_c
);

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q, neg_r_q;

  logic             a_neg_c, b_neg_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic [XLEN:0]    rem_shift_c, diff_c;
  logic [XLEN-1:0]  rem_nx_c, quo_nx_c;

  always_comb begin
    a_neg_c = is_signed & dividend[XLEN-1];
    b_neg_c = is_signed & divisor[XLEN-1];
    a_mag_c = a_neg_c ? -dividend : dividend;
    b_mag_c = b_neg_c ? -divisor  : divisor;
  end

  // Trial subtraction; the partial remainder stays below the divisor so XLEN+1 bits suffice
  always_comb begin
    rem_shift_c = {rem_q, quo_q[XLEN-1]};
    diff_c      = rem_shift_c - {1'b0, dvs_q};
    if (diff_c[XLEN]) begin
      rem_nx_c = rem_shift_c[XLEN-1:0];
      quo_nx_c = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx_c = diff_c[XLEN-1:0];
      quo_nx_c = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q   <= '0;
        quo_q   <= a_mag_c;
        dvs_q   <= b_mag_c;
        cnt_q   <= CNT_W'(XLEN - 1);
        neg_q_q <= a_neg_c ^ b_neg_c;
        neg_r_q <= a_neg_c;
        busy    <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_nx_c;
        quo_q <= quo_nx_c;
        if (cnt_q == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Quotient negated on sign mismatch; remainder follows the dividend's sign
  always_comb begin
    quotient_c  = neg_q_q ? -quo_q : quo_q;
    remainder_c = neg_r_q ? -rem_q : rem_q;
  end

endmodule

// File: rtl/ex_alu_mdu.sv
// Execute-stage ALU with RV32M: single-cycle ALU/MUL, serial divider that stalls via busy.
module ex_alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_ctrl,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_nx;

  logic              accept_c, is_mext_c, is_div_c;
  logic [3:0]        ctrl_c;
  logic [SH_W-1:0]   shamt_c;
  logic [XLEN-1:0]   alu_res_c, mdu_res_c;
  logic              a_sgn_c, b_sgn_c;
  logic [2*XLEN-1:0] mul_a_c, mul_b_c, prod_c;
  logic              div_signed_c, by_zero_c, ovf_c, div_special_c;
  logic [XLEN-1:0]   spec_q_c, spec_r_c;

  logic              div_start_c, div_done, div_is_rem;
  logic [XLEN-1:0]   div_quo_c, div_rem_c;

  logic              out_valid_d, div_is_rem_d;
  logic [XLEN-1:0]   result_d;
  logic [3:0]        alu_ctrl_d;

  assign in_ready = (state == ST_IDLE);
  assign accept_c = in_valid && in_ready && !flush;

  // Decode to the 4-bit control code
  always_comb begin
    is_mext_c = (alu_op == AOP_FUNCT) && !is_imm && (funct7 == FUNCT7_MEXT);
    is_div_c  = is_mext_c && funct3[2];
    ctrl_c    = ALU_ADD;
    case (alu_op)
      AOP_ADD:    ctrl_c = ALU_ADD;
      AOP_SUB:    ctrl_c = ALU_SUB;
      AOP_PASS_B: ctrl_c = ALU_PASS_B;
      default: begin
        if (is_mext_c) begin
          ctrl_c = ALU_MDU;
        end else begin
          case (funct3)
            F3_ADD:  ctrl_c = (!is_imm && funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  ctrl_c = ALU_SLL;
            F3_SLT:  ctrl_c = ALU_SLT;
            F3_SLTU: ctrl_c = ALU_SLTU;
            F3_XOR:  ctrl_c = ALU_XOR;
            F3_SR:   ctrl_c = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   ctrl_c = ALU_OR;
            F3_AND:  ctrl_c = ALU_AND;
            default: ctrl_c = ALU_ADD;
          endcase
        end
      end
    endcase
  end

  // Full-width product; operands extended per MULH/MULHSU/MULHU signedness
  always_comb begin
    a_sgn_c = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    b_sgn_c = (funct3 == F3_MULH);
    mul_a_c = {{XLEN{a_sgn_c & op_a[XLEN-1]}}, op_a};
    mul_b_c = {{XLEN{b_sgn_c & op_b[XLEN-1]}}, op_b};
    prod_c  = mul_a_c * mul_b_c;
  end

  // Divide cases resolved without iterating
  always_comb begin
    div_signed_c  = !funct3[0];
    by_zero_c     = (op_b == '0);
    ovf_c         = div_signed_c && (op_a == XMIN) && (op_b == '1);
    div_special_c = by_zero_c || ovf_c;
    spec_q_c      = by_zero_c ? '1   : XMIN;
    spec_r_c      = by_zero_c ? op_a : '0;
  end

  always_comb begin
    case (funct3)
      F3_MUL:    mdu_res_c = prod_c[XLEN-1:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  mdu_res_c = prod_c[2*XLEN-1:XLEN];
      F3_DIV,
      F3_DIVU:   mdu_res_c = spec_q_c;
      F3_REM,
      F3_REMU:   mdu_res_c = spec_r_c;
      default:   mdu_res_c = '0;
    endcase
  end

  always_comb begin
    shamt_c = op_b[SH_W-1:0];
    case (ctrl_c)
      ALU_ADD:    alu_res_c = op_a + op_b;
      ALU_SUB:    alu_res_c = op_a - op_b;
      ALU_AND:    alu_res_c = op_a & op_b;
      ALU_OR:     alu_res_c = op_a | op_b;
      ALU_XOR:    alu_res_c = op_a ^ op_b;
      ALU_SLL:    alu_res_c = op_a << shamt_c;
      ALU_SRL:    alu_res_c = op_a >> shamt_c;
      ALU_SRA:    alu_res_c = XLEN'($signed(op_a) >>> shamt_c);
      ALU_SLT:    alu_res_c = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:   alu_res_c = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_PASS_B: alu_res_c = op_b;
      ALU_MDU:    alu_res_c = mdu_res_c;
      default:    alu_res_c = '0;
    endcase
  end

  div_serial #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start_c),
    .abort       (flush),
    .is_signed   (div_signed_c),
    .dividend    (op_a),
    .divisor     (op_b),
    .busy        (busy),
    .done        (div_done),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept_c && is_div_c && !div_special_c) state_nx = ST_DIV;
      ST_DIV:  if (flush || div_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d  = 1'b0;
    result_d     = result;
    alu_ctrl_d   = alu_ctrl;
    div_is_rem_d = div_is_rem;
    div_start_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          alu_ctrl_d = ctrl_c;
          if (is_div_c && !div_special_c) begin
            div_start_c  = 1'b1;
            div_is_rem_d = funct3[1];
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
          end
        end
      end
      ST_DIV: begin
        if (!flush && div_done) begin
          out_valid_d = 1'b1;
          result_d    = div_is_rem ? div_rem_c : div_quo_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      alu_ctrl   <= '0;
      div_is_rem <= 1'b0;
    end else begin
      out_valid  <= out_valid_d;
      result     <= result_d;
      alu_ctrl   <= alu_ctrl_d;
      div_is_rem <= div_is_rem_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Randomized self-checking bench for ex_alu_mdu against an arithmetic reference model (XLEN=32).
module tb_ex_alu_mdu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, is_imm;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  alu_ctrl;
  logic        out_valid, busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_ctrl;

  ex_alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .is_imm(is_imm), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected control code, result, and whether the op iterates
  function automatic void model(input logic [1:0] aop, input logic imm, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] ctrl, output logic [31:0] res, output bit multi);
    longint sa, sb, ua, ub, p, q, r;
    int sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    sh = int'(b[4:0]);
    multi = 0; ctrl = 4'd0; res = 32'd0;
    if (aop == 2'd0) begin ctrl = 4'd0; res = a + b; end
    else if (aop == 2'd1) begin ctrl = 4'd1; res = a - b; end
    else if (aop == 2'd3) begin ctrl = 4'd10; res = b; end
    else if (!imm && f7 == 7'h01) begin
      ctrl = 4'd11;
      if (f3 == 3'd0) begin p = sa * sb; res = p[31:0]; end
      else if (f3 == 3'd1) begin p = sa * sb; res = p[63:32]; end
      else if (f3 == 3'd2) begin p = sa * ub; res = p[63:32]; end
      else if (f3 == 3'd3) begin p = ua * ub; res = p[63:32]; end
      else begin
        if (b == 32'd0) begin q = -1; r = sa; end
        else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = sa; r = 0; end
        else begin
          multi = 1;
          if (!f3[0]) begin q = sa / sb; r = sa % sb; end
          else        begin q = ua / ub; r = ua % ub; end
        end
        res = f3[1] ? 32'(r) : 32'(q);
      end
    end else begin
      case (f3)
        3'd0: if (!imm && f7[5]) begin ctrl = 4'd1; res = a - b; end
              else begin ctrl = 4'd0; res = a + b; end
        3'd1: begin ctrl = 4'd5; res = a << sh; end
        3'd2: begin ctrl = 4'd8; res = (sa < sb) ? 32'd1 : 32'd0; end
        3'd3: begin ctrl = 4'd9; res = (ua < ub) ? 32'd1 : 32'd0; end
        3'd4: begin ctrl = 4'd4; res = a ^ b; end
        3'd5: if (f7[5]) begin ctrl = 4'd7; p = sa >>> sh; res = p[31:0]; end
              else begin ctrl = 4'd6; res = a >> sh; end
        3'd6: begin ctrl = 4'd3; res = a | b; end
        default: begin ctrl = 4'd2; res = a & b; end
      endcase
    end
  endfunction

  task automatic drive(input logic [1:0] aop, input logic imm, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    alu_op = aop; is_imm = imm; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
  endtask

  task automatic run_op(input string tag, input logic [1:0] aop, input logic imm,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
    logic [3:0] ectrl;
    logic [31:0] eres;
    bit multi;
    int lat, busy_n;
    model(aop, imm, f3, f7, a, b, ectrl, eres, multi);
    @(negedge clk);
    drive(aop, imm, f3, f7, a, b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_ctrl = ectrl;
    check({tag, "_ctrl"}, 64'(alu_ctrl), 64'(ectrl));
    if (!multi) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_res"}, 64'(result), 64'(eres));
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      lat = 0;
      busy_n = busy ? 1 : 0;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (out_valid) begin lat = n; break; end
        if (busy) busy_n++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check({tag, "_busyn"}, 64'(busy_n), 64'd32);
      check({tag, "_res"}, 64'(result), 64'(eres));
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int vseen;
    logic [1:0] aop;
    logic [6:0] f7;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    drive(2'd0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
    last_ctrl = 4'd0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("rst_ready", 64'(in_ready), 64'd1);

    run_op("addi", 2'b10, 1'b1, 3'd0, 7'h7F, 32'd10, 32'hFFFF_FFFB);
    check("addi_abs", 64'(result), 64'd5);

    // Back-to-back SUB then SRA
    @(negedge clk);
    drive(2'b10, 1'b0, 3'd0, 7'h20, 32'd7, 32'd9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_sub_res", 64'(result), 64'hFFFF_FFFE);
    check("b2b_sub_valid", 64'(out_valid), 64'd1);
    check("b2b_ready0", 64'(in_ready), 64'd1);
    drive(2'b10, 1'b0, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_sra_res", 64'(result), 64'hF800_0000);
    check("b2b_sra_valid", 64'(out_valid), 64'd1);
    check("b2b_sra_ctrl", 64'(alu_ctrl), 64'd7);
    check("b2b_ready1", 64'(in_ready), 64'd1);
    last_ctrl = 4'd7;

    run_op("mulh", 2'b10, 1'b0, 3'd1, 7'h01, 32'hFFFF_FFFE, 32'd3);
    check("mulh_abs", 64'(result), 64'hFFFF_FFFF);
    run_op("mulhu", 2'b10, 1'b0, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_abs", 64'(result), 64'hFFFF_FFFE);
    run_op("div", 2'b10, 1'b0, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
    check("div_abs", 64'(result), 64'hFFFF_FFFD);
    run_op("rem", 2'b10, 1'b0, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2);
    check("rem_abs", 64'(result), 64'hFFFF_FFFF);
    run_op("divu0", 2'b10, 1'b0, 3'd5, 7'h01, 32'd5, 32'd0);
    check("divu0_abs", 64'(result), 64'hFFFF_FFFF);
    run_op("removf", 2'b10, 1'b0, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    check("removf_abs", 64'(result), 64'd0);
    run_op("divovf", 2'b10, 1'b0, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_abs", 64'(result), 64'h8000_0000);

    // Flush in IDLE with an op presented drops it
    @(negedge clk);
    drive(2'b00, 1'b0, 3'd0, 7'd0, 32'd1, 32'd2);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_drop_valid", 64'(out_valid), 64'd0);
    check("flush_drop_ctrl", 64'(alu_ctrl), 64'(last_ctrl));

    // Flush on the 10th cycle of a divide
    @(negedge clk);
    drive(2'b10, 1'b0, 3'd4, 7'h01, 32'd1000, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("dflush_valid", 64'(out_valid), 64'd0);
    check("dflush_ready", 64'(in_ready), 64'd1);
    check("dflush_busy", 64'(busy), 64'd0);
    vseen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) vseen++; end
    check("dflush_noresult", 64'(vseen), 64'd0);
    run_op("post_flush_add", 2'b00, 1'b0, 3'd0, 7'd0, 32'd20, 32'd22);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    drive(2'b10, 1'b0, 3'd5, 7'h01, 32'd12345, 32'd17);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_ctrl", 64'(alu_ctrl), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;
    last_ctrl = 4'd0;
    run_op("post_rst_divu", 2'b10, 1'b0, 3'd5, 7'h01, 32'd100, 32'd7);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 8))
        0: aop = 2'b00;
        1: aop = 2'b01;
        2: aop = 2'b11;
        default: aop = 2'b10;
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = ($urandom_range(0, 1) == 0) ? 7'h01 : 7'($urandom);
      endcase
      run_op("rnd", aop, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), f7,
             rnd_operand(), rnd_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_mdu.md
Name: ex_alu_mdu

Overview:
- Parametrised execute-stage arithmetic unit: decodes alu_op/funct3/funct7 into the 4-bit ALU control encoding and computes the result, adding RV32M multiply/divide.
- ALU ops and MUL* complete in one cycle. DIV/DIVU/REM/REMU run on an iterative restoring divider, and the unit stalls the pipeline for the duration.
- Sits between ID/EX and EX/MEM. Pipeline hazard logic consumes `busy`.

Parameters:
- XLEN, 32, operand/result width (≥8, power of 2).
- CNT_W, $clog2(XLEN), divider iteration counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- flush, input, 1, synchronous pipeline flush.
- in_valid, input, 1, operation presented this cycle.
- in_ready, output, 1, unit can accept.
- alu_op, input, 2, 00 ADD, 01 SUB, 10 funct-decode, 11 PASS_B.
- is_imm, input, 1, I-type (funct7 ignored except shifts).
- funct3, input, 3, instruction funct3.
- funct7, input, 7, instruction funct7.
- op_a, input, XLEN, rs1 value.
- op_b, input, XLEN, rs2 value / immediate.
- alu_ctrl, output, 4, registered control code of the last accepted op.
- out_valid, output, 1, one-cycle result pulse.
- result, output, XLEN, registered result.
- busy, output, 1, divider iterating (pipeline stall).

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - out_valid=0, result=0, alu_ctrl=0, busy=0
  - counter=0, divider registers=0
  - in_ready=1 after reset release.
- Decode codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASS_B 1010.
- SUB is selected only when alu_op=10, funct3=000, is_imm=0 and funct7[5]=1. ADDI with a negative immediate is ADD.
- SRA/SRAI are selected by funct7[5]. Shift amount is op_b[$clog2(XLEN)-1:0].
- M-ext is selected when alu_op=10, is_imm=0 and funct7=0000001. funct3 then selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. alu_ctrl is set to 1011 for M ops.
- Acceptance: an op is accepted when in_valid && in_ready && !flush. in_ready = (state==IDLE).
- States:
  - IDLE: on acceptance of a non-divide op, register result and set out_valid=1 next cycle; stay in IDLE. Throughput is 1 op/cycle. On acceptance of a divide with a special case, behave as a single-cycle op. On acceptance of any other divide, latch operands, counter=XLEN-1, go to DIV.
  - DIV: one quotient bit per cycle, counter decrements. busy=1, in_ready=0. When counter==0, register the final result, set out_valid=1 next cycle, go to IDLE.
  - Total divide latency: out_valid is asserted XLEN+1 cycles after the acceptance edge.
- Multiply: full 2·XLEN product. MULH, MULHSU and MULHU return the upper XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Signed divide: operate on magnitudes. Negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Special divide cases (1-cycle, no iteration):
  - Divisor 0: quotient = all ones, remainder = op_a.
  - Signed overflow (op_a=MIN, op_b=−1): quotient = MIN, remainder = 0.
- out_valid is a single-cycle pulse. result holds its value until the next completion.
- flush:
  - Returns to IDLE and clears counter.
  - Forces out_valid=0 next cycle, cancelling an in-flight single-cycle result or divide.
  - flush together with in_valid drops the input.
  - flush in IDLE with no op has no effect.
- Asynchronous rst mid-divide: immediate return to reset values. The partial result is discarded.

Decomposition:
- Shared package `alu_pkg`:
  - ALU_* 4-bit control localparams, including ALU_MDU=1011.
  - funct3 M-op constants.
  - alu_op encodings.
  - FUNCT7_MEXT=7'b0000001.
- One sub-module: `div_serial` (XLEN-parametrised restoring divider, start/done handshake, sign fix-up). The decode, multiplier and FSM stay in ex_alu_mdu.

Test Plan (XLEN=32):
- ADDI: alu_op=10, is_imm=1, funct3=000, funct7=7'h7F, op_a=10, op_b=32'hFFFF_FFFB → alu_ctrl=0000, result=5, out_valid one cycle later.
- Back-to-back, one op per cycle: SUB 7−9, then SRA 0x8000_0000>>4 → results 0xFFFF_FFFE then 0xF800_0000 on consecutive cycles; in_ready stays 1.
- MULH −2×3 → 0xFFFF_FFFF; MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE.
- DIV −7/2 → quotient 0xFFFF_FFFD, out_valid exactly 33 cycles after acceptance, busy high 32 cycles. REM −7/2 → 0xFFFF_FFFF.
- Special cases:
  - DIVU 5/0 → 0xFFFF_FFFF in 1 cycle.
  - REM 0x8000_0000/−1 → 0.
  - DIV 0x8000_0000/−1 → 0x8000_0000.
- Abort cases:
  - flush at cycle 10 of a DIV → no out_valid, in_ready=1 next cycle; a new ADD is accepted.
  - rst asserted asynchronously mid-DIV → all outputs at reset values before the next clock edge.
